// File: rtl/cr_tlvp_ob_arb_pkg.sv
// ---------------------------------------------------------------------------
// cr_tlvp_ob_arb_pkg
// Shared types and constants for the TLV parser user-output arbiter.
//   tlvp_if_bus_t            : one TLV word as carried on the parser usr_ob bus
//   CR_ERR_TLVP_OB_FRAME_OVF : error code raised to the error aggregator when
//                              a frame runs past the per-frame word limit
//   arb_state_e              : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package cr_tlvp_ob_arb_pkg;

  // Same layout as the TLV bus word used across the cr_* blocks.
  typedef struct packed {
    logic        sot;
    logic        eot;
    logic [7:0]  typen;
    logic [63:0] tdata;
  } tlvp_if_bus_t;

  localparam logic [7:0] CR_ERR_TLVP_OB_FRAME_OVF = 8'h5a;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cr_rr_pick.sv
// ---------------------------------------------------------------------------
// cr_rr_pick
// Combinational round-robin first-set finder. Starting at ptr and scanning
// ptr, ptr+1, ... modulo N, returns the first index whose req bit is set.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   valid : at least one request is set
//   idx   : winning index (0 when valid is low)
// ---------------------------------------------------------------------------
module cr_rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // Scan from the farthest position back toward ptr so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational variable unassigned would infer a latch.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(ptr) + k) % N);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cr_tlvp_ob_arb.sv
// ---------------------------------------------------------------------------
// cr_tlvp_ob_arb
// Frame-atomic round-robin arbiter sharing the parser usr_ob write port
// between N_REQ engine output FIFOs. Locks onto one requester per frame,
// drains it to its last word, then re-arbitrates.
//   clk, rst       : clock, synchronous active-high reset
//   req_empty      : per-requester FIFO empty
//   req_tlv        : per-requester head-of-FIFO TLV word
//   req_last       : head word closes its frame
//   req_rd         : pop strobe to the owner's FIFO (one-hot or zero)
//   usr_ob_afull   : parser user-output FIFO almost full (blocks pops)
//   usr_ob_wr      : registered write strobe, one cycle after the pop
//   usr_ob_tlv     : registered TLV word, holds between writes
//   cur_owner      : locked requester index (zero-extended, valid while busy)
//   busy           : a frame is in progress
//   frame_ovf_err  : sticky, a frame ran past MAX_FRAME_WORDS words
// The write lags the pop by one cycle, so the parser afull threshold must
// leave room for one in-flight word (N_UF_AFULL_VAL >= 2).
// ---------------------------------------------------------------------------
module cr_tlvp_ob_arb
  import cr_tlvp_ob_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_FRAME_WORDS = 4096,
  parameter int FCNT_WIDTH      = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_empty,
  input  tlvp_if_bus_t [N_REQ-1:0] req_tlv,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_rd,
  input  logic                     usr_ob_afull,
  output logic                     usr_ob_wr,
  output tlvp_if_bus_t             usr_ob_tlv,
  output logic [2:0]               cur_owner,
  output logic                     busy,
  output logic                     frame_ovf_err
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [FCNT_WIDTH-1:0] FCNT_MAX  = '1;
  localparam logic [FCNT_WIDTH-1:0] FCNT_LAST = FCNT_WIDTH'(MAX_FRAME_WORDS - 1);
  localparam logic [PW-1:0]         OWN_MAX   = PW'(N_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         owner_q, rr_ptr_q, pick_idx;
  logic                  pick_valid;
  logic                  pop;
  logic                  owner_last;
  tlvp_if_bus_t          owner_tlv;
  tlvp_if_bus_t          tlv_q;
  logic [FCNT_WIDTH-1:0] fcnt_q;
  logic                  wr_q;
  logic                  ovf_q;

  cr_rr_pick #(
    .N (N_REQ),
    .W (PW)
  ) u_rr_pick (
    .req   (~req_empty),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_tlv  = req_tlv[owner_q];
  assign owner_last = req_last[owner_q];

  // Pop is gated by rst so a frame abandoned by reset never drains a word.
  assign pop = !rst && (state_q == ARB_BUSY) && !req_empty[owner_q] && !usr_ob_afull;

  always_comb begin
    req_rd          = '0;
    req_rd[owner_q] = pop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_valid)          state_d = ARB_BUSY;
      ARB_BUSY: if (pop && owner_last)   state_d = ARB_IDLE;
      default:                           state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      fcnt_q   <= '0;
      wr_q     <= 1'b0;
      // NOTE: the data register is reset too, because usr_ob_tlv must read
      // zero out of reset rather than whatever the flops power up with.
      tlv_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_q <= pop;
      if (pop) tlv_q <= owner_tlv;

      // Grant and pop are mutually exclusive: grant only in IDLE, pop only in BUSY.
      if (state_q == ARB_IDLE && pick_valid) begin
        owner_q <= pick_idx;
        fcnt_q  <= '0;
      end else if (pop && fcnt_q != FCNT_MAX) begin
        fcnt_q <= fcnt_q + 1'b1;
      end

      // Word MAX_FRAME_WORDS popped without closing the frame: flag, keep forwarding.
      if (pop && fcnt_q == FCNT_LAST && !owner_last) ovf_q <= 1'b1;

      if (pop && owner_last) rr_ptr_q <= (owner_q == OWN_MAX) ? '0 : owner_q + 1'b1;
    end
  end

  assign usr_ob_wr     = wr_q;
  assign usr_ob_tlv    = tlv_q;
  assign busy          = (state_q == ARB_BUSY);
  assign cur_owner     = 3'(owner_q);
  assign frame_ovf_err = ovf_q;

endmodule

// File: tb/tb_cr_tlvp_ob_arb.sv
// ---------------------------------------------------------------------------
// tb_cr_tlvp_ob_arb
// Self-checking bench for cr_tlvp_ob_arb (N_REQ=4, MAX_FRAME_WORDS=8).
// Requester FIFOs are modelled as queues; a frame-level reference model
// predicts pops, writes and status each cycle.
// ---------------------------------------------------------------------------
module tb_cr_tlvp_ob_arb;
  import cr_tlvp_ob_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXW = 8;
  localparam int FW   = 4;
  localparam int FMAX = (1 << FW) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_empty;
  tlvp_if_bus_t [N-1:0] req_tlv;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_rd;
  logic               usr_ob_afull;
  logic               usr_ob_wr;
  tlvp_if_bus_t       usr_ob_tlv;
  logic [2:0]         cur_owner;
  logic               busy;
  logic               frame_ovf_err;

  always #5 clk = ~clk;

  cr_tlvp_ob_arb #(
    .N_REQ           (N),
    .MAX_FRAME_WORDS (MAXW),
    .FCNT_WIDTH      (FW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_empty     (req_empty),
    .req_tlv       (req_tlv),
    .req_last      (req_last),
    .req_rd        (req_rd),
    .usr_ob_afull  (usr_ob_afull),
    .usr_ob_wr     (usr_ob_wr),
    .usr_ob_tlv    (usr_ob_tlv),
    .cur_owner     (cur_owner),
    .busy          (busy),
    .frame_ovf_err (frame_ovf_err)
  );

  typedef struct {
    tlvp_if_bus_t tlv;
    bit           last;
  } item_t;

  item_t fifo [N][$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  bit           m_busy, m_ovf, m_wr;
  int           m_owner, m_ptr, m_fcnt;
  tlvp_if_bus_t m_tlv;

  // last sampled DUT outputs
  logic [N-1:0] obs_rd;
  logic         obs_wr, obs_busy, obs_ovf;
  tlvp_if_bus_t obs_tlv;
  logic [2:0]   obs_owner;

  function automatic tlvp_if_bus_t mk_word(int r, int seq, bit last);
    tlvp_if_bus_t w;
    w.sot   = (seq == 1);
    w.eot   = last;
    w.typen = 8'(r);
    w.tdata = {16'(r), 16'(seq), $urandom};
    return w;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (fifo[i].size() != 0) begin
        req_empty[i] = 1'b0;
        req_tlv[i]   = fifo[i][0].tlv;
        req_last[i]  = fifo[i][0].last;
      end else begin
        req_empty[i] = 1'b1;
        req_tlv[i]   = '0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic push(input int r, input int seq, input bit last, output tlvp_if_bus_t w);
    item_t it;
    it.tlv  = mk_word(r, seq, last);
    it.last = last;
    w       = it.tlv;
    fifo[r].push_back(it);
    drive_inputs();
  endtask

  task automatic push_frame(input int r, input int len);
    tlvp_if_bus_t w;
    for (int s = 1; s <= len; s++) push(r, s, s == len, w);
  endtask

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_fcnt  = 0;
    m_ovf   = 1'b0;
    m_wr    = 1'b0;
    m_tlv   = '0;
  endfunction

  // One clock: sample outputs at negedge, compare against the model,
  // advance the model, then apply the pop to the FIFO queues after posedge.
  task automatic step();
    logic [N-1:0] exp_rd;
    bit           pop, found;
    int           pown, c;
    item_t        it;
    @(negedge clk);
    cyc++;
    obs_rd    = req_rd;
    obs_wr    = usr_ob_wr;
    obs_tlv   = usr_ob_tlv;
    obs_busy  = busy;
    obs_owner = cur_owner;
    obs_ovf   = frame_ovf_err;

    pop    = !rst && m_busy && (fifo[m_owner].size() != 0) && !usr_ob_afull;
    pown   = m_owner;
    exp_rd = '0;
    if (pop) exp_rd[pown] = 1'b1;

    n_checks++;
    if (obs_rd !== exp_rd) begin
      n_fail++; $display("FAIL model_req_rd cyc %0d: got %b want %b", cyc, obs_rd, exp_rd);
    end
    n_checks++;
    if (obs_wr !== m_wr) begin
      n_fail++; $display("FAIL model_usr_ob_wr cyc %0d: got %b want %b", cyc, obs_wr, m_wr);
    end
    n_checks++;
    if (obs_tlv !== m_tlv) begin
      n_fail++; $display("FAIL model_usr_ob_tlv cyc %0d: got %h want %h", cyc, obs_tlv, m_tlv);
    end
    n_checks++;
    if (obs_busy !== m_busy) begin
      n_fail++; $display("FAIL model_busy cyc %0d: got %b want %b", cyc, obs_busy, m_busy);
    end
    n_checks++;
    if (obs_ovf !== m_ovf) begin
      n_fail++; $display("FAIL model_ovf cyc %0d: got %b want %b", cyc, obs_ovf, m_ovf);
    end
    if (m_busy) begin
      n_checks++;
      if (obs_owner !== 3'(m_owner)) begin
        n_fail++; $display("FAIL model_owner cyc %0d: got %0d want %0d", cyc, obs_owner, m_owner);
      end
    end

    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      m_wr = pop;
      if (pop) begin
        it    = fifo[pown][0];
        m_tlv = it.tlv;
        if (m_fcnt == MAXW - 1 && !it.last) m_ovf = 1'b1;
        if (m_fcnt < FMAX) m_fcnt++;
        if (it.last) begin
          m_busy = 1'b0;
          m_ptr  = (pown + 1) % N;
        end
      end
    end else begin
      m_wr  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && fifo[c].size() != 0) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = c;
          m_fcnt  = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    if (pop) void'(fifo[pown].pop_front());
    drive_inputs();
  endtask

  task automatic do_reset();
    usr_ob_afull = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done;
    usr_ob_afull = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (fifo[0].size() == 0 && fifo[1].size() == 0 && fifo[2].size() == 0 &&
          fifo[3].size() == 0 && !m_busy && !m_wr) done = 1'b1;
      else step();
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL drain_timeout_%s: got busy=%b want drained", tag, obs_busy);
    end
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    n_checks++;
    if (obs_rd !== '0 || obs_wr !== 1'b0 || obs_tlv !== '0 || obs_owner !== 3'd0 ||
        obs_busy !== 1'b0 || obs_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b wr=%b tlv=%h own=%0d busy=%b ovf=%b want all 0",
               obs_rd, obs_wr, obs_tlv, obs_owner, obs_busy, obs_ovf);
    end
  endtask

  task automatic test_single_frame();
    tlvp_if_bus_t w [3];
    logic [N-1:0] rd_h [8];
    bit           wr_h [8], busy_h [8];
    tlvp_if_bus_t tlv_h [8];
    tlvp_if_bus_t dummy;
    do_reset();
    for (int s = 0; s < 3; s++) push(2, s + 1, s == 2, w[s]);
    for (int c = 0; c < 8; c++) begin
      step();
      rd_h[c] = obs_rd; wr_h[c] = obs_wr; busy_h[c] = obs_busy; tlv_h[c] = obs_tlv;
    end
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (rd_h[c] !== ((c >= 1 && c <= 3) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("FAIL single_rd c%0d: got %b", c, rd_h[c]);
      end
      n_checks++;
      if (wr_h[c] !== (c >= 2 && c <= 4)) begin
        n_fail++; $display("FAIL single_wr c%0d: got %b", c, wr_h[c]);
      end
      n_checks++;
      if (busy_h[c] !== (c >= 1 && c <= 3)) begin
        n_fail++; $display("FAIL single_busy c%0d: got %b", c, busy_h[c]);
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (tlv_h[c] !== w[c-2]) begin
          n_fail++; $display("FAIL single_word c%0d: got %h want %h", c, tlv_h[c], w[c-2]);
        end
      end
    end
    // rr_ptr should now be 3: with 0 and 3 both pending, 3 wins.
    push(0, 1, 1'b1, dummy);
    push(3, 1, 1'b1, dummy);
    step();
    step();
    n_checks++;
    if (obs_busy !== 1'b1 || obs_owner !== 3'd3) begin
      n_fail++; $display("FAIL single_rr_ptr: got busy=%b own=%0d want busy=1 own=3", obs_busy, obs_owner);
    end
    drain("single");
  endtask

  task automatic test_round_robin();
    int owners[$];
    int idle_run;
    bit seen;
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < N; r++) push_frame(r, 1);
    idle_run = 0;
    seen     = 1'b0;
    for (int c = 0; c < 18; c++) begin
      step();
      n_checks++;
      if ($countones(obs_rd) > 1) begin
        n_fail++; $display("FAIL rr_onehot c%0d: got %b", c, obs_rd);
      end
      if (obs_busy) begin
        if (seen) begin
          n_checks++;
          if (idle_run != 1) begin
            n_fail++; $display("FAIL rr_gap c%0d: got %0d idle cycles want 1", c, idle_run);
          end
        end
        owners.push_back(int'(obs_owner));
        seen     = 1'b1;
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
    n_checks++;
    if (owners.size() != 8) begin
      n_fail++; $display("FAIL rr_frame_count: got %0d want 8", owners.size());
    end
    for (int i = 0; i < owners.size() && i < 8; i++) begin
      n_checks++;
      if (owners[i] != i % N) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, owners[i], i % N);
      end
    end
    drain("rr");
  endtask

  task automatic test_afull_stall();
    do_reset();
    push_frame(1, 6);
    step();                 // grant to 1
    push_frame(0, 1);       // competitor appears mid-frame
    step();                 // pop w1
    step();                 // pop w2
    usr_ob_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (obs_rd !== '0 || obs_owner !== 3'd1 || obs_busy !== 1'b1) begin
        n_fail++; $display("FAIL afull_hold i%0d: got rd=%b own=%0d busy=%b", i, obs_rd, obs_owner, obs_busy);
      end
      n_checks++;
      if (obs_wr !== (i == 0)) begin
        n_fail++; $display("FAIL afull_wr i%0d: got %b want %b", i, obs_wr, i == 0);
      end
    end
    usr_ob_afull = 1'b0;
    step();
    n_checks++;
    if (obs_rd !== 4'b0010) begin
      n_fail++; $display("FAIL afull_resume: got %b want 0010", obs_rd);
    end
    drain("afull");
  endtask

  task automatic test_owner_starve();
    tlvp_if_bus_t w3, w4, dummy;
    tlvp_if_bus_t wr_seen[$];
    do_reset();
    push(0, 1, 1'b0, dummy);
    push(0, 2, 1'b0, dummy);
    for (int r = 1; r < N; r++) push_frame(r, 1);
    step(); step(); step();  // grant, pop w1, pop w2
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs_busy !== 1'b1 || obs_owner !== 3'd0 || obs_rd !== '0) begin
        n_fail++; $display("FAIL starve_hold i%0d: got busy=%b own=%0d rd=%b", i, obs_busy, obs_owner, obs_rd);
      end
    end
    push(0, 3, 1'b0, w3);
    push(0, 4, 1'b1, w4);
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_wr) wr_seen.push_back(obs_tlv);
    end
    n_checks++;
    if (wr_seen.size() < 2 || wr_seen[0] !== w3 || wr_seen[1] !== w4) begin
      n_fail++; $display("FAIL starve_tail: got %0d writes want w3,w4 first", wr_seen.size());
    end
    drain("starve");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    push_frame(2, 5);
    step();                 // grant to 2
    step();                 // pop w1
    rst = 1'b1;
    step();                 // would-be pop of w2, reset wins
    n_checks++;
    if (obs_rd !== '0) begin
      n_fail++; $display("FAIL rstmid_no_pop: got %b want 0000", obs_rd);
    end
    rst = 1'b0;
    push_frame(0, 1);
    step();
    n_checks++;
    if (obs_rd !== '0 || obs_wr !== 1'b0 || obs_tlv !== '0 || obs_owner !== 3'd0 ||
        obs_busy !== 1'b0 || obs_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got rd=%b wr=%b tlv=%h own=%0d busy=%b ovf=%b want all 0",
               obs_rd, obs_wr, obs_tlv, obs_owner, obs_busy, obs_ovf);
    end
    step();
    n_checks++;
    if (obs_busy !== 1'b1 || obs_owner !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_restart: got busy=%b own=%0d want busy=1 own=0", obs_busy, obs_owner);
    end
    drain("rstmid");
  endtask

  task automatic test_frame_overflow();
    int npop, nwr;
    do_reset();
    push_frame(3, MAXW);    // exactly at the limit: no error
    drain("ovf_exact");
    n_checks++;
    if (frame_ovf_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_exact_limit: got %b want 0", frame_ovf_err);
    end
    push_frame(1, 10);
    npop = 0;
    nwr  = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      n_checks++;
      if (obs_ovf !== (npop >= MAXW)) begin
        n_fail++; $display("FAIL ovf_timing c%0d: got %b want %b", c, obs_ovf, npop >= MAXW);
      end
      if (obs_rd[1]) npop++;
      if (obs_wr) nwr++;
    end
    n_checks++;
    if (nwr != 10 || obs_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_forward: got %0d writes ovf=%b want 10 ovf=1", nwr, obs_ovf);
    end
    do_reset();
    step();
    n_checks++;
    if (obs_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", obs_ovf);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r = int'($urandom_range(0, N - 1));
        if (fifo[r].size() < 12) push_frame(r, int'($urandom_range(1, 10)));
      end
      usr_ob_afull = ($urandom_range(0, 3) == 0);
      step();
    end
    drain("random");
  endtask

  initial begin
    rst          = 1'b1;
    usr_ob_afull = 1'b0;
    drive_inputs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_afull_stall();
    test_owner_starve();
    test_reset_mid_frame();
    test_frame_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
